alu_acc_flags_core: RTL and testbench

- 8-bit accumulator ALU with a registered carry flag, a registered overflow flag, and combinational zero/sign flags.
- Selects one operand from an immediate, register-file output, or memory output.
- Combines that operand with the accumulator under a 4-bit opcode.
- Sits in the simple CPU datapath between the operand buses and the accumulator/flag consumers, such as the branch logic.

---
 rtl/alu_acc_flags_core.sv | 193 +++++++++++++++++++
 tb/tb_alu_acc_flags_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_flags_core.sv
// alu_acc_flags_core: accumulator ALU with registered carry and overflow flags.
// Inputs: operand bus select, opcode, enables. Outputs: operand B, A, flags.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous reset, active low
//   data_src   operand select: 0/3 immediate, 1 reg_out, 2 mem_out
//   immediate  immediate operand
//   reg_out    register-file operand
//   mem_out    memory operand
//   op         4-bit opcode
//   ce_a       accumulator and overflow-flag write enable
//   ce_cy      carry-flag write enable
//   alu_in     selected operand B (combinational)
//   acc_v      accumulator A
//   flag_cy    registered carry / borrow
//   flag_z     A == 0 (combinational from A)
//   flag_s     sign bit of A (combinational from A)
//   flag_o     registered signed overflow
module alu_acc_flags_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       data_src,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] reg_out,
  input  logic [WIDTH-1:0] mem_out,
  input  logic [3:0]       op,
  input  logic             ce_a,
  input  logic             ce_cy,
  output logic [WIDTH-1:0] alu_in,
  output logic [WIDTH-1:0] acc_v,
  output logic             flag_cy,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_o
);

  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_RCL = 4'd11;
  localparam logic [3:0] OP_RCR = 4'd12;
  localparam logic [3:0] OP_INC = 4'd13;
  localparam logic [3:0] OP_DEC = 4'd14;
  localparam logic [3:0] OP_CMP = 4'd15;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] acc;
  logic             cy;
  logic             ov_q;

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             c_nxt;
  logic             ov_nxt;

  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic             add_ci;
  logic [WIDTH:0]   ext;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;
  logic             add_ov;
  logic             sub_ov;

  always_comb begin
    unique case (data_src)
      2'd1:    b = reg_out;
      2'd2:    b = mem_out;
      default: b = immediate;
    endcase
  end

  // One shared WIDTH+1 adder/subtractor; bit WIDTH is carry or borrow.
  always_comb begin
    add_b   = b;
    add_sub = 1'b0;
    add_ci  = 1'b0;
    unique case (op)
      OP_ADC: add_ci = cy;
      OP_SUB,
      OP_CMP: add_sub = 1'b1;
      OP_SBC: begin
        add_sub = 1'b1;
        add_ci  = cy;
      end
      OP_INC: add_b = ONE;
      OP_DEC: begin
        add_b   = ONE;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (add_sub)
      ext = {1'b0, acc} - {1'b0, add_b}
          - {{WIDTH{1'b0}}, add_ci};
    else
      ext = {1'b0, acc} + {1'b0, add_b}
          + {{WIDTH{1'b0}}, add_ci};
  end

  assign a_msb  = acc[WIDTH-1];
  assign b_msb  = add_b[WIDTH-1];
  assign r_msb  = ext[WIDTH-1];
  assign add_ov = (a_msb == b_msb) && (r_msb != a_msb);
  assign sub_ov = (a_msb != b_msb) && (r_msb != a_msb);

  always_comb begin
    res    = acc;
    c_nxt  = 1'b0;
    ov_nxt = 1'b0;
    unique case (op)
      OP_LD:  res = b;
      OP_ADD,
      OP_ADC,
      OP_INC: begin
        res    = ext[WIDTH-1:0];
        c_nxt  = ext[WIDTH];
        ov_nxt = add_ov;
      end
      OP_SUB,
      OP_SBC,
      OP_DEC: begin
        res    = ext[WIDTH-1:0];
        c_nxt  = ext[WIDTH];
        ov_nxt = sub_ov;
      end
      OP_AND: res = acc & b;
      OP_OR:  res = acc | b;
      OP_XOR: res = acc ^ b;
      OP_NOT: res = ~acc;
      OP_SHL: begin
        res   = {acc[WIDTH-2:0], 1'b0};
        c_nxt = acc[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, acc[WIDTH-1:1]};
        c_nxt = acc[0];
      end
      OP_RCL: begin
        res   = {acc[WIDTH-2:0], cy};
        c_nxt = acc[WIDTH-1];
      end
      OP_RCR: begin
        res   = {cy, acc[WIDTH-1:1]};
        c_nxt = acc[0];
      end
      // Compare keeps A; only the flags see A-B.
      OP_CMP: begin
        c_nxt  = ext[WIDTH];
        ov_nxt = sub_ov;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc  <= '0;
      cy   <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      if (ce_a) begin
        acc  <= res;
        ov_q <= ov_nxt;
      end
      if (ce_cy)
        cy <= c_nxt;
    end
  end

  assign alu_in  = b;
  assign acc_v   = acc;
  assign flag_cy = cy;
  assign flag_o  = ov_q;
  assign flag_z  = (acc == '0);
  assign flag_s  = acc[WIDTH-1];

endmodule

// File: tb/tb_alu_acc_flags_core.sv
// tb_alu_acc_flags_core: directed and random checks of alu_acc_flags_core
// against an integer-arithmetic reference model.
module tb_alu_acc_flags_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] data_src;
  logic [7:0] immediate;
  logic [7:0] reg_out;
  logic [7:0] mem_out;
  logic [3:0] op;
  logic       ce_a;
  logic       ce_cy;
  logic [7:0] alu_in;
  logic [7:0] acc_v;
  logic       flag_cy;
  logic       flag_z;
  logic       flag_s;
  logic       flag_o;

  int total = 0;
  int bad   = 0;

  int ma  = 0;
  int mcy = 0;
  int mo  = 0;

  alu_acc_flags_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_src  (data_src),
    .immediate (immediate),
    .reg_out   (reg_out),
    .mem_out   (mem_out),
    .op        (op),
    .ce_a      (ce_a),
    .ce_cy     (ce_cy),
    .alu_in    (alu_in),
    .acc_v     (acc_v),
    .flag_cy   (flag_cy),
    .flag_z    (flag_z),
    .flag_s    (flag_s),
    .flag_o    (flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int ovf(input int s);
    return (s > 127 || s < -128) ? 1 : 0;
  endfunction

  function automatic int wrap(input int v);
    return (v + 512) % 256;
  endfunction

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input int a, input int b, input int cy,
                       input logic [3:0] o,
                       output int r, output int c, output int ov);
    int sa, sb;
    sa = sgn(a);
    sb = sgn(b);
    r = a; c = 0; ov = 0;
    case (o)
      4'd0:  r = b;
      4'd1:  begin r = wrap(a + b); c = (a + b > 255); ov = ovf(sa + sb); end
      4'd2:  begin
        r = wrap(a + b + cy); c = (a + b + cy > 255); ov = ovf(sa + sb + cy);
      end
      4'd3:  begin r = wrap(a - b); c = (a < b); ov = ovf(sa - sb); end
      4'd4:  begin
        r = wrap(a - b - cy); c = (a - b - cy < 0); ov = ovf(sa - sb - cy);
      end
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = 255 - a;
      4'd9:  begin r = (a * 2) % 256; c = a / 128; end
      4'd10: begin r = a / 2; c = a % 2; end
      4'd11: begin r = (a * 2) % 256 + cy; c = a / 128; end
      4'd12: begin r = a / 2 + cy * 128; c = a % 2; end
      4'd13: begin r = wrap(a + 1); c = (a == 255); ov = ovf(sa + 1); end
      4'd14: begin r = wrap(a - 1); c = (a == 0); ov = ovf(sa - 1); end
      default: begin r = a; c = (a < b); ov = ovf(sa - sb); end
    endcase
  endtask

  task automatic step(input logic rn, input logic ea, input logic ec,
                      input logic [3:0] o, input logic [1:0] s,
                      input logic [7:0] im, input logic [7:0] rg,
                      input logic [7:0] mm);
    int b, r, c, ov;
    rst = rn; ce_a = ea; ce_cy = ec; op = o;
    data_src = s; immediate = im; reg_out = rg; mem_out = mm;
    b = (s == 2'd1) ? int'(rg) : (s == 2'd2) ? int'(mm) : int'(im);
    #1;
    chk("alu_in", alu_in, 8'(b));
    model(ma, b, mcy, o, r, c, ov);
    @(posedge clk);
    if (!rn) begin
      ma = 0; mcy = 0; mo = 0;
    end else begin
      if (ea) begin ma = r; mo = ov; end
      if (ec) mcy = c;
    end
    #1;
    chk("acc_v", acc_v, 8'(ma));
    chk("flag_cy", {7'd0, flag_cy}, 8'(mcy));
    chk("flag_o", {7'd0, flag_o}, 8'(mo));
    chk("flag_z", {7'd0, flag_z}, (ma == 0) ? 8'd1 : 8'd0);
    chk("flag_s", {7'd0, flag_s}, 8'(ma / 128));
  endtask

  task automatic ld(input logic [7:0] v);
    step(1, 1, 0, 4'd0, 2'd0, v, 8'h00, 8'h00);
  endtask

  task automatic alu(input logic [3:0] o, input logic [7:0] v);
    step(1, 1, 1, o, 2'd0, v, 8'h00, 8'h00);
  endtask

  initial begin
    step(0, 0, 0, 4'd0, 2'd0, 8'h00, 8'h00, 8'h00);
    // Arbitrary state, then reset overriding enables.
    ld(8'hC3);
    alu(4'd1, 8'hC3);
    step(0, 1, 1, 4'd1, 2'd0, 8'hFF, 8'h00, 8'h00);
    chk("rst_acc", acc_v, 8'h00);
    chk("rst_z", {7'd0, flag_z}, 8'd1);
    chk("rst_cy", {7'd0, flag_cy}, 8'd0);
    // Load from each source.
    step(1, 1, 0, 4'd0, 2'd0, 8'h5A, 8'h11, 8'h22);
    chk("ld_imm", acc_v, 8'h5A);
    step(1, 1, 0, 4'd0, 2'd1, 8'h11, 8'h33, 8'h22);
    chk("ld_reg", acc_v, 8'h33);
    step(1, 1, 0, 4'd0, 2'd2, 8'h11, 8'h22, 8'h80);
    chk("ld_mem", acc_v, 8'h80);
    chk("ld_mem_s", {7'd0, flag_s}, 8'd1);
    step(1, 1, 0, 4'd0, 2'd3, 8'h44, 8'h22, 8'h80);
    chk("ld_src3", acc_v, 8'h44);
    // Arithmetic.
    ld(8'h7F);
    alu(4'd1, 8'h01);
    chk("add_ov_acc", acc_v, 8'h80);
    chk("add_ov_o", {7'd0, flag_o}, 8'd1);
    ld(8'hFF);
    alu(4'd1, 8'h01);
    chk("add_wrap_cy", {7'd0, flag_cy}, 8'd1);
    chk("add_wrap_z", {7'd0, flag_z}, 8'd1);
    alu(4'd2, 8'h00);
    chk("adc_acc", acc_v, 8'h01);
    ld(8'h00);
    alu(4'd3, 8'h01);
    chk("sub_acc", acc_v, 8'hFF);
    chk("sub_cy", {7'd0, flag_cy}, 8'd1);
    alu(4'd4, 8'h00);
    chk("sbc_acc", acc_v, 8'hFE);
    // Logic, shift, rotate.
    ld(8'hF0); alu(4'd5, 8'h3C);
    chk("and", acc_v, 8'h30);
    ld(8'hF0); alu(4'd6, 8'h0F);
    chk("or", acc_v, 8'hFF);
    ld(8'hF0); alu(4'd7, 8'hFF);
    chk("xor", acc_v, 8'h0F);
    alu(4'd8, 8'h00);
    alu(4'd9, 8'h00);
    alu(4'd10, 8'h00);
    ld(8'h81);
    step(1, 0, 1, 4'd0, 2'd0, 8'h00, 8'h00, 8'h00);
    alu(4'd11, 8'h00);
    chk("rcl_acc", acc_v, 8'h02);
    chk("rcl_cy", {7'd0, flag_cy}, 8'd1);
    alu(4'd12, 8'h00);
    chk("rcr_acc", acc_v, 8'h81);
    chk("rcr_cy", {7'd0, flag_cy}, 8'd0);
    alu(4'd13, 8'h00);
    alu(4'd14, 8'h00);
    ld(8'h80); alu(4'd14, 8'h00);
    chk("dec_ov", {7'd0, flag_o}, 8'd1);
    // Independent enables.
    ld(8'hF0);
    step(1, 0, 1, 4'd1, 2'd0, 8'h20, 8'h00, 8'h00);
    chk("ce_cy_only_acc", acc_v, 8'hF0);
    chk("ce_cy_only_cy", {7'd0, flag_cy}, 8'd1);
    step(1, 1, 0, 4'd3, 2'd0, 8'h01, 8'h00, 8'h00);
    chk("ce_a_only_acc", acc_v, 8'hEF);
    chk("ce_a_only_cy", {7'd0, flag_cy}, 8'd1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 4'($urandom), 2'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom));
    chk("hold_acc", acc_v, 8'hEF);
    // Compare.
    ld(8'h10);
    alu(4'd15, 8'h20);
    chk("cmp_acc", acc_v, 8'h10);
    chk("cmp_cy", {7'd0, flag_cy}, 8'd1);
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom),
           4'($urandom), 2'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
